// File: rtl/core_seq_pkg.sv
// Shared sequencer definitions: state encodings, state bus width and the reset instruction.
// Imported by core_seq and its watchdog sub-module.
package core_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    // States that sit on an external handshake and may stall.
    function automatic logic is_wait_state(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/core_seq_wdog.sv
// seq_wdog: counts consecutive cycles spent in a handshake-wait state; trips on the last allowed cycle.
// Zero-latency trip output from the count register; the counter restarts whenever the wait ends.
module seq_wdog #(
    parameter int LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic wait_i,
    output logic trip_o
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Leaving the wait state (handshake or trip) clears the count for the next entry.
    always_comb begin
        cnt_d = '0;
        if (wait_i) begin
            cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign trip_o = wait_i && (cnt_q == LAST);

endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; CORE_SEQ_WDOG_EN adds a handshake watchdog.
// 4 cycles per instruction (5 with MEM) plus one per wait on inst_valid_i/mem_ack_i; waits are unbounded without the watchdog.
module core_seq
    import core_seq_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          WDOG_LIMIT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    output logic               inst_req_o,
    input  logic               inst_valid_i,
    input  logic [31:0]        inst_i,
    output logic [63:0]        pc_o,
    output logic [31:0]        ir_o,
    input  logic               ren_mem_i,
    input  logic               wen_mem_i,
    input  logic               wen_reg_i,
    input  logic               ebreak_i,
    input  logic [63:0]        npc_i,
    output logic               exec_en_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    input  logic               mem_ack_i,
    output logic               wb_en_o,
    output logic               retire_o,
    output logic               halt_o,
    output logic               err_o,
    output logic [STATE_W-1:0] state_o
);

    seq_state_e  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] npc_q, npc_d;
    logic [31:0] ir_q, ir_d;
    logic        mem_we_q, mem_we_d;
    logic        wen_reg_q, wen_reg_d;
    logic        retire_q, retire_d;
    logic        err_q, err_d;
    logic        wdog_trip;

`ifdef CORE_SEQ_WDOG_EN
    seq_wdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .wait_i (is_wait_state(state_q)),
        .trip_o (wdog_trip)
    );
`else
    // No counter: a stalled handshake simply waits.
    assign wdog_trip = (WDOG_LIMIT < 0);
`endif

    // Decoder flags are captured in EXEC so every output stays a function of registers only.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        npc_d     = npc_q;
        ir_d      = ir_q;
        mem_we_d  = mem_we_q;
        wen_reg_d = wen_reg_q;
        retire_d  = 1'b0;
        err_d     = err_q;

        case (state_q)
            ST_FETCH: begin
                if (inst_valid_i) begin
                    ir_d    = inst_i;
                    state_d = ST_DECODE;
                end else if (wdog_trip) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                npc_d     = npc_i;
                mem_we_d  = wen_mem_i;
                wen_reg_d = wen_reg_i;
                if (ebreak_i) begin
                    state_d  = ST_HALT;
                    retire_d = 1'b1;
                end else if (ren_mem_i || wen_mem_i) begin
                    state_d = ST_MEM;
                end else begin
                    state_d  = ST_WB;
                    retire_d = 1'b1;
                end
            end
            ST_MEM: begin
                if (mem_ack_i) begin
                    state_d  = ST_WB;
                    retire_d = 1'b1;
                end else if (wdog_trip) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end
            end
            ST_WB: begin
                pc_d    = npc_q;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            npc_q     <= RESET_PC;
            ir_q      <= INSN_NOP;
            mem_we_q  <= 1'b0;
            wen_reg_q <= 1'b0;
            retire_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            ir_q      <= ir_d;
            mem_we_q  <= mem_we_d;
            wen_reg_q <= wen_reg_d;
            retire_q  <= retire_d;
            err_q     <= err_d;
        end
    end

    assign inst_req_o = (state_q == ST_FETCH);
    assign exec_en_o  = (state_q == ST_EXEC);
    assign mem_req_o  = (state_q == ST_MEM);
    assign mem_we_o   = (state_q == ST_MEM) && mem_we_q;
    assign wb_en_o    = (state_q == ST_WB) && wen_reg_q;
    assign halt_o     = (state_q == ST_HALT);
    assign retire_o   = retire_q;
    assign err_o      = err_q;
    assign pc_o       = pc_q;
    assign ir_o       = ir_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: random fetch/memory responders and a decoder/exu model feed the DUT,
// expected retirements are queued at issue and checked by an independent monitor.
`timescale 1ns/1ps
module tb_core_seq;

    localparam logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000;
    localparam int          WDOG_LIMIT = 16;
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;
    localparam logic [31:0] ADDI       = 32'h0010_0093;
    localparam logic [31:0] LD         = 32'h0000_B103;
    localparam logic [31:0] SD         = 32'h0020_B423;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req_o, inst_valid_i;
    logic [31:0] inst_i, ir_o;
    logic [63:0] pc_o, npc_i;
    logic        ren_mem_i, wen_mem_i, wen_reg_i, ebreak_i;
    logic        exec_en_o, mem_req_o, mem_we_o, mem_ack_i;
    logic        wb_en_o, retire_o, halt_o, err_o;
    logic [2:0]  state_o;

    always #5 clock = ~clock;

    core_seq #(
        .RESET_PC   (RESET_PC),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .inst_req_o   (inst_req_o),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .pc_o         (pc_o),
        .ir_o         (ir_o),
        .ren_mem_i    (ren_mem_i),
        .wen_mem_i    (wen_mem_i),
        .wen_reg_i    (wen_reg_i),
        .ebreak_i     (ebreak_i),
        .npc_i        (npc_i),
        .exec_en_o    (exec_en_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_ack_i    (mem_ack_i),
        .wb_en_o      (wb_en_o),
        .retire_o     (retire_o),
        .halt_o       (halt_o),
        .err_o        (err_o),
        .state_o      (state_o)
    );

    typedef struct { logic [31:0] insn; int fw; int mw; bit noexp; } stim_t;
    typedef struct { logic [63:0] pc; bit wb; bit we; int mreq; int lat; } exp_t;

    stim_t       stim_q[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur_mw   = 0;
    logic [63:0] last_ret_pc = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Decoder and exu models.
    function automatic bit dec_load(input logic [31:0] i);   return i[6:0] == 7'b0000011; endfunction
    function automatic bit dec_store(input logic [31:0] i);  return i[6:0] == 7'b0100011; endfunction
    function automatic bit dec_branch(input logic [31:0] i); return i[6:0] == 7'b1100011; endfunction
    function automatic bit dec_ebreak(input logic [31:0] i); return i == EBREAK; endfunction
    function automatic bit dec_wreg(input logic [31:0] i);
        return !(dec_store(i) || dec_branch(i) || dec_ebreak(i));
    endfunction
    function automatic logic [63:0] exu_npc(input logic [63:0] pc, input logic [31:0] i);
        return dec_branch(i) ? pc + 64'(i[11:7]) * 64'd8 + 64'd8 : pc + 64'd4;
    endfunction

    assign ren_mem_i = dec_load(ir_o);
    assign wen_mem_i = dec_store(ir_o);
    assign wen_reg_i = dec_wreg(ir_o);
    assign ebreak_i  = dec_ebreak(ir_o);
    assign npc_i     = exu_npc(pc_o, ir_o);

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return {r[31:7], 7'b0010011};
            1:       return {r[31:7], 7'b0000011};
            2:       return {r[31:7], 7'b0100011};
            default: return {r[31:7], 7'b1100011};
        endcase
    endfunction

    task automatic push_stim(input logic [31:0] insn, input int fw, input int mw, input bit noexp);
        stim_t s;
        s.insn = insn; s.fw = fw; s.mw = mw; s.noexp = noexp;
        stim_q.push_back(s);
    endtask

    task automatic push_random(input int n);
        for (int k = 0; k < n; k++)
            push_stim(rand_insn(), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0);
    endtask

    // Fetch responder: issues stimulus, queues the expected retirement, tracks the architectural PC.
    initial begin : fetch_side
        stim_t       s;
        exp_t        e;
        int          fw = 0;
        int          idle = 0;
        bit          issued = 1'b0;
        bit          is_mem;
        logic [63:0] mpc = RESET_PC;
        logic [31:0] cur = NOP;
        inst_valid_i = 1'b0;
        inst_i = NOP;
        forever begin
            @(negedge clock);
            if (reset) begin
                issued = 1'b0; idle = 0; mpc = RESET_PC;
                inst_valid_i = 1'($urandom_range(0, 1)); inst_i = $urandom;
            end else if (inst_req_o) begin
                if (!issued) begin
                    if (stim_q.size() > 0) begin
                        s = stim_q.pop_front();
                        issued = 1'b1; fw = s.fw; cur = s.insn; cur_mw = s.mw;
                        is_mem = dec_load(cur) || dec_store(cur);
                        if (!s.noexp) begin
                            e.pc   = mpc;
                            e.wb   = dec_wreg(cur);
                            e.we   = dec_store(cur);
                            e.mreq = is_mem ? s.mw + 1 : 0;
                            e.lat  = 4 + s.fw + idle + (is_mem ? 1 + s.mw : 0);
                            exp_q.push_back(e);
                        end
                        idle = 0;
                        if (!dec_ebreak(cur)) mpc = exu_npc(mpc, cur);
                    end else begin
                        idle++;
                    end
                end
                if (issued && fw == 0) begin
                    inst_valid_i = 1'b1; inst_i = cur;
                end else begin
                    inst_valid_i = 1'b0; inst_i = $urandom;
                    if (issued) fw--;
                end
            end else begin
                issued = 1'b0;
                inst_valid_i = 1'($urandom_range(0, 1)); inst_i = $urandom;
            end
        end
    end

    // Data-memory responder; acks outside a request are noise the DUT must ignore.
    initial begin : mem_side
        int mw = 0;
        bit started = 1'b0;
        mem_ack_i = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                started = 1'b0; mem_ack_i = 1'b1;
            end else if (mem_req_o) begin
                if (!started) begin started = 1'b1; mw = cur_mw; end
                if (mw == 0) mem_ack_i = 1'b1;
                else begin mem_ack_i = 1'b0; mw--; end
            end else begin
                started = 1'b0; mem_ack_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : monitor
        int   cyc = 0, nreq = 0, nwb = 0, nex = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete(); cyc = 0; nreq = 0; nwb = 0; nex = 0;
            end else begin
                cyc++;
                if (exec_en_o) nex++;
                if (wb_en_o) nwb++;
                if (mem_req_o) begin
                    nreq++;
                    if (exp_q.size() > 0) check("mem_we", 64'(mem_we_o), 64'(exp_q[0].we));
                end
                if (retire_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 64'(retire_o), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        last_ret_pc = e.pc;
                        check("retire_pc", pc_o, e.pc);
                        check("latency", 64'(cyc), 64'(e.lat));
                        check("wb_en_count", 64'(nwb), 64'(e.wb));
                        check("mem_req_cycles", 64'(nreq), 64'(e.mreq));
                        check("exec_en_count", 64'(nex), 64'd1);
                    end
                    cyc = 0; nreq = 0; nwb = 0; nex = 0;
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", 64'(n >= budget), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, 64'(state_o), 64'd0);
        check({tag, "_pc"}, pc_o, RESET_PC);
        check({tag, "_inst_req"}, 64'(inst_req_o), 64'd1);
        check({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
        check({tag, "_retire"}, 64'(retire_o), 64'd0);
        check({tag, "_halt"}, 64'(halt_o), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
    endtask

    initial begin : main
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_state("reset");
        check("reset_ir", 64'(ir_o), 64'(NOP));
        check("reset_exec_en", 64'(exec_en_o), 64'd0);
        check("reset_wb_en", 64'(wb_en_o), 64'd0);

        // Zero-wait addi, load with a 3-cycle ack delay, zero-wait store, then random traffic.
        push_stim(ADDI, 0, 0, 1'b0);
        push_stim(LD, 0, 3, 1'b0);
        push_stim(SD, 0, 0, 1'b0);
        push_random(40);
        @(posedge clock); #1 reset = 1'b0;
        wait_drain(3000);

        // Reset while a load waits on its ack.
        push_stim(LD, 0, 10, 1'b0);
        n = 0;
        while (!mem_req_o && n < 100) begin @(negedge clock); n++; end
        check("mem_entry_timeout", 64'(n >= 100), 64'd0);
        repeat (2) @(negedge clock);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_reset_state("midmem");
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("late_ack_ignored", 64'(mem_req_o), 64'd0);
        end

        push_random(20);
        push_stim(EBREAK, 1, 0, 1'b0);
        wait_drain(2000);
        check("halt_set", 64'(halt_o), 64'd1);
        check("halt_state", 64'(state_o), 64'd5);
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            check("halt_no_fetch", 64'(inst_req_o), 64'd0);
            check("halt_pc_hold", pc_o, last_ret_pc);
        end
        check("halt_no_err", 64'(err_o), 64'd0);

`ifdef CORE_SEQ_WDOG_EN
        // Fetch never answered: the watchdog stops the core after WDOG_LIMIT fetch cycles.
        @(posedge clock); #1 reset = 1'b1;
        push_stim(ADDI, 1000, 0, 1'b1);
        @(posedge clock); #1 reset = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (halt_o) break;
            if (inst_req_o) n++;
        end
        check("wdog_fetch_cycles", 64'(n), 64'(WDOG_LIMIT));
        check("wdog_halt", 64'(halt_o), 64'd1);
        check("wdog_err", 64'(err_o), 64'd1);

        // A fetch answered on the limit cycle completes without error.
        @(posedge clock); #1 reset = 1'b1;
        push_stim(ADDI, WDOG_LIMIT - 1, 0, 1'b0);
        @(posedge clock); #1 reset = 1'b0;
        wait_drain(200);
        check("wdog_limit_no_err", 64'(err_o), 64'd0);
        check("wdog_limit_no_halt", 64'(halt_o), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : timeout
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multi-cycle sequencer for the RV64 core.
- Owns the PC and instruction register and drives the instruction-fetch and data-memory request handshakes.
- Steps each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
- Sits between the fetch interface, the decoder (reads its `renMem` / `wenMem` / `wenReg` / `ebreak` outputs) and the `exu`/`lsu`/regfile, issuing one-cycle enables to each.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- WDOG_LIMIT, 1024, cycles a memory handshake may wait before the watchdog trips (used only with `CORE_SEQ_WDOG_EN`).

Ports:
- clock  in  1  core clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_req_o  out  1  fetch request; held high in FETCH until accepted.
- inst_valid_i  in  1  fetch data valid; counted only while `inst_req_o`=1.
- inst_i  in  32  fetched instruction.
- pc_o  out  64  current PC; also the fetch address.
- ir_o  out  32  latched instruction; feeds the decoder.
- ren_mem_i  in  1  decoder load flag.
- wen_mem_i  in  1  decoder store flag.
- wen_reg_i  in  1  decoder register-write flag.
- ebreak_i  in  1  decoder ebreak flag.
- npc_i  in  64  next PC from `exu`; sampled in EXEC.
- exec_en_o  out  1  one-cycle `exu` enable.
- mem_req_o  out  1  data request; held high in MEM until acknowledged.
- mem_we_o  out  1  store qualifier; valid while `mem_req_o`=1.
- mem_ack_i  in  1  data handshake complete; counted only while `mem_req_o`=1.
- wb_en_o  out  1  one-cycle regfile write enable.
- retire_o  out  1  one-cycle pulse per completed instruction.
- halt_o  out  1  sticky; core stopped.
- err_o  out  1  sticky watchdog error; tied 0 without `CORE_SEQ_WDOG_EN`.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (sync, active-high, takes priority over every transition):
  - state=FETCH, `pc_o`=RESET_PC, `ir_o`=32'h0000_0013 (nop).
  - `halt_o`=0, `err_o`=0; all pulses and requests 0 from the edge after reset is sampled high.
  - Reset mid-handshake abandons the request; no retry or completion is recorded.
- All outputs are registered or decoded from the state register only; no combinational path from any `_i` to any `_o`.
- FETCH:
  - `inst_req_o`=1.
  - On an edge with `inst_valid_i`=1: `ir_o`<=`inst_i`, go to DECODE.
  - A valid arriving in the same cycle that req first rises is accepted (zero-wait memory allowed).
- DECODE: one cycle; decoder outputs settle from `ir_o`. Go to EXEC.
- EXEC:
  - `exec_en_o`=1 for exactly one cycle.
  - If `ebreak_i`: go to HALT; PC not updated; `retire_o` pulses on the HALT entry cycle.
  - Else if `ren_mem_i` or `wen_mem_i`: go to MEM.
  - Else: go to WB.
  - `npc_i` is captured into an internal register this cycle.
- MEM:
  - `mem_req_o`=1; `mem_we_o`=`wen_mem_i`.
  - On `mem_ack_i`: go to WB.
  - Both load and store flags set simultaneously cannot come from legal decode; store wins.
- WB:
  - `wb_en_o`=`wen_reg_i` (stores, branches and system instructions give 0).
  - `pc_o`<=captured npc; `retire_o`=1; go to FETCH.
- HALT: absorbing; `halt_o`=1; no requests. Left only via reset.
- Latency:
  - Zero-wait non-memory instruction: 4 cycles FETCH-entry to next FETCH-entry.
  - Zero-wait load/store: 5 cycles.
  - Each wait cycle on `inst_valid_i` or `mem_ack_i` adds one cycle.
- `pc_o` changes only in WB or on reset; no wrap check (64-bit arithmetic happens in `exu`).

Optional Feature:
- Macro `CORE_SEQ_WDOG_EN`.
- Defined:
  - Counter clears on entry to FETCH and to MEM, and counts each cycle spent waiting.
  - Reaching WDOG_LIMIT-1 with no handshake: next state HALT, `err_o`=1 sticky.
  - A handshake arriving on the limit cycle wins; no error.
- Undefined: no counter is built; waits are unbounded; `err_o`=0.

Decomposition:
- Shared define header (with the existing decoder bus defines):
  - state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5;
  - state bus width 3;
  - nop encoding constant.
- One natural sub-module, `seq_wdog`: the counter plus limit compare, instantiated only under the macro.

Test Plan:
- Reset then `addi` with zero-wait fetch (`inst_valid_i` tied 1) -> `pc_o` goes 0x8000_0000 -> npc 0x8000_0004 four cycles after reset release; `wb_en_o` pulses once; `retire_o` pulses once.
- `ld` with `mem_ack_i` delayed 3 cycles -> `mem_req_o` high for 4 cycles, `mem_we_o`=0; `wb_en_o` on the cycle after ack; 8 cycles total.
- `sd` -> `mem_we_o`=1 throughout MEM; `wb_en_o` stays 0; `retire_o` pulses once.
- `ebreak` (0x0010_0073) -> `halt_o`=1 from the cycle after EXEC; `inst_req_o` stays 0 for 50 further cycles; `pc_o` unchanged.
- Reset asserted while in MEM with ack pending -> next edge gives state=FETCH, `mem_req_o`=0, `pc_o`=RESET_PC; a late `mem_ack_i` is ignored.
- `CORE_SEQ_WDOG_EN`, WDOG_LIMIT=16, `inst_valid_i` held 0 -> HALT with `err_o`=1 after 16 FETCH cycles; repeating with valid on cycle 16 gives no error.
